// File: rtl/pipeline_sequencer_pkg.sv
// Shared encodings and constants for the pipeline sequencer.
package pipeline_sequencer_pkg;

  localparam int unsigned STATE_W            = 3;
  localparam int unsigned CYCLE_CNT_SIZE_DEF = 32;

  localparam logic LOW   = 1'b0;
  localparam logic HIGH  = 1'b1;
  localparam logic CLEAR = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_HALTED = 3'd3,
    ST_FLUSH  = 3'd4
  } state_e;

endpackage

// File: rtl/pipeline_sequencer.sv
// Drives PC and inter-stage register enables/flushes for the five-stage pipeline.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned CYCLE_CNT_SIZE = CYCLE_CNT_SIZE_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_run,
  input  logic                      i_pause,
  input  logic                      i_step,
  input  logic                      i_clear,
  input  logic                      i_halt_wb,
  input  logic                      i_stall,
  input  logic                      i_branch_flush,
  output logic                      o_pc_enable,
  output logic                      o_if_id_enable,
  output logic                      o_id_ex_enable,
  output logic                      o_ex_mem_enable,
  output logic                      o_mem_wb_enable,
  output logic                      o_if_id_flush,
  output logic                      o_id_ex_flush,
  output logic                      o_ex_mem_flush,
  output logic                      o_mem_wb_flush,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [STATE_W-1:0]        o_state,
  output logic [CYCLE_CNT_SIZE-1:0] o_cycle_count
);

  state_e                    state_q, state_d;
  logic [CYCLE_CNT_SIZE-1:0] cnt_q, cnt_d;
  logic                      adv_c;

  // Pipeline advances only while running/stepping and no HALT has reached WB.
  assign adv_c = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !i_halt_wb;

  // Next-state selection; clear overrides everything, halt beats pause.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_run)       state_d = ST_RUN;
          else if (i_step) state_d = ST_STEP;
        end
        ST_RUN: begin
          if (i_halt_wb)    state_d = ST_HALTED;
          else if (i_pause) state_d = ST_IDLE;
        end
        ST_STEP: begin
          if (i_halt_wb) state_d = ST_HALTED;
          else           state_d = ST_IDLE;
        end
        ST_HALTED: state_d = ST_HALTED;
        ST_FLUSH:  state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Saturating advance counter, zeroed on entry to the flush state so it reads 0 during it.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == ST_FLUSH) begin
      cnt_d = '0;
    end else if (adv_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CYCLE_CNT_SIZE'(1);
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Enable/flush decode: stall inserts an ID/EX bubble and masks the branch flush.
  always_comb begin
    o_pc_enable     = LOW;
    o_if_id_enable  = LOW;
    o_id_ex_enable  = LOW;
    o_ex_mem_enable = LOW;
    o_mem_wb_enable = LOW;
    o_if_id_flush   = LOW;
    o_id_ex_flush   = LOW;
    o_ex_mem_flush  = LOW;
    o_mem_wb_flush  = LOW;
    if (state_q == ST_FLUSH) begin
      o_if_id_flush  = CLEAR;
      o_id_ex_flush  = CLEAR;
      o_ex_mem_flush = CLEAR;
      o_mem_wb_flush = CLEAR;
    end else if (adv_c) begin
      o_ex_mem_enable = HIGH;
      o_mem_wb_enable = HIGH;
      if (i_stall) begin
        o_id_ex_flush = CLEAR;
      end else begin
        o_pc_enable    = HIGH;
        o_if_id_enable = HIGH;
        o_id_ex_enable = HIGH;
        o_if_id_flush  = i_branch_flush;
      end
    end
  end

  assign o_busy        = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign o_done        = (state_q == ST_HALTED);
  assign o_state       = state_q;
  assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: driver queues expected outputs, monitor compares mid-cycle.
module tb_pipeline_sequencer;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0, pause = 1'b0, step = 1'b0, clear = 1'b0;
  logic          halt = 1'b0, stall = 1'b0, br = 1'b0;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl;
  logic          busy, done;
  logic [2:0]    state;
  logic [CW-1:0] cnt;

  typedef struct {
    string       nm;
    logic [17:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipeline_sequencer #(.CYCLE_CNT_SIZE(CW)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_run(run), .i_pause(pause), .i_step(step), .i_clear(clear),
    .i_halt_wb(halt), .i_stall(stall), .i_branch_flush(br),
    .o_pc_enable(pc_en), .o_if_id_enable(if_id_en), .o_id_ex_enable(id_ex_en),
    .o_ex_mem_enable(ex_mem_en), .o_mem_wb_enable(mem_wb_en),
    .o_if_id_flush(if_id_fl), .o_id_ex_flush(id_ex_fl),
    .o_ex_mem_flush(ex_mem_fl), .o_mem_wb_flush(mem_wb_fl),
    .o_busy(busy), .o_done(done), .o_state(state), .o_cycle_count(cnt)
  );

  // Pack expectation: enables {pc,if_id,id_ex,ex_mem,mem_wb}, flushes {if_id,id_ex,ex_mem,mem_wb}.
  function automatic logic [17:0] ex(input logic [4:0] en, input logic [3:0] fl,
                                     input logic b, input logic d,
                                     input logic [2:0] st, input logic [CW-1:0] c);
    return {en, fl, b, d, st, c};
  endfunction

  // Apply one cycle of inputs just after the edge and queue the expected mid-cycle outputs.
  task automatic drive(input string nm, input logic r, input logic ru, input logic pa,
                       input logic stp, input logic cl, input logic h, input logic s,
                       input logic b, input logic [17:0] e);
    exp_t item;
    @(posedge clk);
    #1;
    rst_n = r; run = ru; pause = pa; step = stp; clear = cl;
    halt = h; stall = s; br = b;
    item.nm  = nm;
    item.exp = e;
    sb.push_back(item);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation on each falling edge.
  initial begin
    exp_t        item;
    logic [17:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        item = sb.pop_front();
        got  = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl, busy, done, state, cnt};
        checks++;
        if (got !== item.exp) begin
          errors++;
          $display("FAIL %s: got=%05h exp=%05h (t=%0t)", item.nm, got, item.exp, $time);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] c;
    // Reset state.
    drive("reset0", 0,0,0,0,0,0,0,0, ex(5'b0,4'b0,0,0,3'd0,4'd0));
    drive("reset1", 0,1,0,1,0,0,0,0, ex(5'b0,4'b0,0,0,3'd0,4'd0));
    // Release and issue run.
    drive("idle_run", 1,1,0,0,0,0,0,0, ex(5'b0,4'b0,0,0,3'd0,4'd0));
    for (int k = 0; k < 10; k++) begin
      c = CW'(k);
      drive("run10", 1,0,(k == 9),0,0,0,0,0, ex(5'b11111,4'b0,1,0,3'd1,c));
    end
    drive("paused", 1,0,0,0,1,0,0,0, ex(5'b0,4'b0,0,0,3'd0,4'd10));
    drive("flush_a", 1,0,0,0,0,0,0,0, ex(5'b0,4'b1111,0,0,3'd4,4'd0));
    drive("idle_a", 1,0,0,0,0,0,0,0, ex(5'b0,4'b0,0,0,3'd0,4'd0));
    // Three single steps; a second step pulse inside STEP is dropped.
    for (int s = 0; s < 3; s++) begin
      c = CW'(s);
      drive("step_req", 1,0,0,1,0,0,0,0, ex(5'b0,4'b0,0,0,3'd0,c));
      drive("step_adv", 1,0,0,(s == 1),0,0,0,0, ex(5'b11111,4'b0,1,0,3'd2,c));
      c = CW'(s + 1);
      drive("step_back", 1,0,0,0,0,0,0,0, ex(5'b0,4'b0,0,0,3'd0,c));
      drive("step_idle", 1,0,0,0,0,0,0,0, ex(5'b0,4'b0,0,0,3'd0,c));
    end
    // Stall and branch hazards, then halt at count 7.
    drive("idle_run2", 1,1,0,0,0,0,0,0, ex(5'b0,4'b0,0,0,3'd0,4'd3));
    drive("run_plain", 1,0,0,0,0,0,0,0, ex(5'b11111,4'b0,1,0,3'd1,4'd3));
    drive("stall_br", 1,0,0,0,0,0,1,1, ex(5'b00011,4'b0100,1,0,3'd1,4'd4));
    drive("branch", 1,0,0,0,0,0,0,1, ex(5'b11111,4'b1000,1,0,3'd1,4'd5));
    drive("run_step_ign", 1,0,0,1,0,0,0,0, ex(5'b11111,4'b0,1,0,3'd1,4'd6));
    drive("halt_arrive", 1,0,0,0,0,1,0,0, ex(5'b0,4'b0,1,0,3'd1,4'd7));
    drive("halted_cmds", 1,1,0,1,0,1,0,0, ex(5'b0,4'b0,0,1,3'd3,4'd7));
    drive("halted_pause", 1,0,1,0,0,1,0,0, ex(5'b0,4'b0,0,1,3'd3,4'd7));
    drive("halted_clear", 1,0,0,0,1,1,0,0, ex(5'b0,4'b0,0,1,3'd3,4'd7));
    drive("flush_b", 1,0,0,0,0,0,0,0, ex(5'b0,4'b1111,0,0,3'd4,4'd0));
    drive("idle_b", 1,1,0,1,0,0,0,0, ex(5'b0,4'b0,0,0,3'd0,4'd0));
    // Run+step together picks RUN; count saturates at all-ones.
    for (int k = 0; k < 20; k++) begin
      c = (k > 15) ? 4'hF : CW'(k);
      drive("run_sat", 1,0,0,0,0,0,0,0, ex(5'b11111,4'b0,1,0,3'd1,c));
    end
    // Async reset in the middle of a run.
    drive("mid_reset", 0,0,0,0,0,0,0,0, ex(5'b0,4'b0,0,0,3'd0,4'd0));
    drive("post_reset", 1,0,0,0,0,0,0,0, ex(5'b0,4'b0,0,0,3'd0,4'd0));
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: queue=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Sequences the five-stage MIPS pipeline: drives the PC and all four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with per-register enable and flush signals. Runs the pipeline continuously or one clock at a time on debug-unit command, inserts load-use bubbles and branch flushes, and freezes the pipeline when a HALT instruction reaches WB. Sits between the debug unit, the hazard unit and the pipeline registers.

## Interface
- CYCLE_CNT_SIZE, 32, width of executed-cycle counter
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_run  in  1  pulse: start continuous execution
- i_pause  in  1  pulse: stop continuous execution
- i_step  in  1  pulse: execute exactly one clock
- i_clear  in  1  pulse: flush whole pipeline, return to idle
- i_halt_wb  in  1  halt flag out of MEM/WB register
- i_stall  in  1  load-use stall request from hazard unit
- i_branch_flush  in  1  taken branch/jump resolved in ID
- o_pc_enable, o_if_id_enable, o_id_ex_enable, o_ex_mem_enable, o_mem_wb_enable  out  1 each  register enables
- o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_mem_wb_flush  out  1 each  register flushes
- o_busy  out  1  state is RUN or STEP
- o_done  out  1  state is HALTED
- o_state  out  3  current state encoding
- o_cycle_count  out  CYCLE_CNT_SIZE  clocks in which pipeline advanced

## Operation
- States: IDLE=0, RUN=1, STEP=2, HALTED=3, FLUSH=4.
- adv (combinational) = (state RUN or STEP) and not i_halt_wb.
- adv=1: ex_mem, mem_wb enables high; pc, if_id, id_ex enables high unless i_stall.
- i_stall with adv: pc_enable=0, if_id_enable=0, id_ex_flush=1 (bubble); i_branch_flush ignored that clock (stall wins).
- i_branch_flush with adv and no stall: if_id_flush=1.
- adv=0 outside FLUSH: all enables and flushes low.
- FLUSH: all four flushes high, all enables low, for exactly one clock.
- Transitions, priority top-down:
  - i_clear in any state -> FLUSH.
  - RUN or STEP with i_halt_wb=1 -> HALTED (pipeline frozen the same clock, no advance).
  - IDLE: i_run -> RUN; else i_step -> STEP; i_run and i_step together -> RUN.
  - RUN: i_pause -> IDLE; i_step ignored.
  - STEP: unconditionally -> IDLE after one clock.
  - HALTED: i_run, i_step, i_pause ignored; only i_clear leaves.
  - FLUSH -> IDLE.
- Counter: +1 on every clock with adv=1, stall clocks included; saturates at all-ones; cleared in FLUSH.

## Timing
- Reset (i_reset=0, async): state IDLE, counter 0; all enables/flushes 0, o_busy=0, o_done=0, o_state=0.
- Command pulse sampled at edge N; new state and its enables valid in cycle N+1.
- Enables/flushes combinational from registered state plus i_halt_wb, i_stall, i_branch_flush; no pipeline-register input is registered here.
- Step: exactly one adv clock per i_step accepted; pulses arriving in STEP dropped.
- i_halt_wb rising while RUN: zero further advances; HALTED from next edge; o_done high from next cycle until FLUSH.
- Reset mid-operation: immediate return to IDLE, counter 0, no flush pulse generated (pipeline registers take their own reset).

## Structure
- Shared package/header: state encodings, CYCLE_CNT_SIZE default, LOW/HIGH/CLEAR macros.
- Single module; no sub-module: state register, next-state logic, saturating counter, output decode.

## Test plan
- Reset then i_run, no hazards, 10 clocks -> all five enables high, o_busy=1, o_cycle_count=10.
- IDLE, i_step ×3 spaced 4 clocks -> exactly 3 single-cycle enable pulses, count=3, state back to 0 each time.
- RUN with i_stall one clock and i_branch_flush same clock -> pc/if_id enable 0, id_ex_flush 1, if_id_flush 0; next clock with branch only -> if_id_flush 1.
- RUN, i_halt_wb asserted at count 7 -> enables 0 that clock, o_state=3, o_done=1, count stays 7; i_run/i_step then ignored.
- HALTED, i_clear -> one clock of all four flushes, o_state=4, count 0, then IDLE.
- RUN, i_reset low mid-run -> outputs 0 asynchronously, count 0; counter at all-ones with adv -> remains all-ones.
